// File: rtl/muldiv_pkg.sv
// Shared types and opcode helpers for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  // RISC-V funct3 encodings for the M extension
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  // Remainder variants (REM/REMU) return the remainder rather than the quotient
  function automatic logic is_rem(input muldiv_op_e op);
    return op[2] & op[1];
  endfunction

  // Operand a is treated as signed for MUL/MULH/MULHSU and for DIV/REM
  function automatic logic is_signed_a(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Operand b is treated as signed for MUL/MULH and for DIV/REM
  function automatic logic is_signed_b(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Restoring divider, one quotient bit per cycle on unsigned magnitudes.
module muldiv_div_iter #(
  parameter int dataW = 32
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             start,
  input  logic             clear,
  input  logic [dataW-1:0] dividend,
  input  logic [dataW-1:0] divisor,
  output logic [dataW-1:0] quo,
  output logic [dataW-1:0] rem,
  output logic             done
);

  localparam int CW = $clog2(dataW + 1);

  logic [CW-1:0]    counter;
  logic [dataW-1:0] div_q;
  logic [dataW:0]   rem_sh;
  logic             fits;
  logic [dataW-1:0] rem_next;

  // Shift {rem,quo} left and trial-subtract; rem_sh is one bit wider because
  // 2*rem+1 can exceed dataW bits when the divisor is near 2^dataW.
  always_comb begin
    rem_sh   = {rem, quo[dataW-1]};
    fits     = (rem_sh >= {1'b0, div_q});
    rem_next = fits ? (rem_sh[dataW-1:0] - div_q) : rem_sh[dataW-1:0];
  end

  // Iteration registers; clear returns the counter to zero so a later
  // special-case divide sees done immediately.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      counter <= '0;
      rem     <= '0;
      quo     <= '0;
      div_q   <= '0;
    end else if (clear) begin
      counter <= '0;
    end else if (start) begin
      counter <= CW'(dataW);
      rem     <= '0;
      quo     <= dividend;
      div_q   <= divisor;
    end else if (counter != '0) begin
      counter <= counter - CW'(1);
      rem     <= rem_next;
      quo     <= {quo[dataW-2:0], fits};
    end
  end

  assign done = (counter == '0);

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// RV32M execute sequencer: single-cycle registered multiply, iterative divide,
// result returned over a valid/ready handshake.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready
// && !flush; a response transfers on a rising edge where resp_valid && resp_ready.
// resp_valid/resp_data stay stable until that transfer or a flush.
module muldiv_seq_ctrl
  import muldiv_pkg::*;
#(
  parameter int dataW = 32
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [dataW-1:0] req_a,
  input  logic [dataW-1:0] req_b,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [dataW-1:0] resp_data,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam logic [dataW-1:0] MIN_VAL = {1'b1, {(dataW-1){1'b0}}};

  state_e           state, state_next;
  muldiv_op_e       op_in, op_q;
  logic [dataW-1:0] a_q, b_q;
  logic             neg_q, neg_r, special_q;
  logic             accept, sgn_in, special_in;
  logic [dataW-1:0] a_abs, b_abs;
  logic             div_start, div_done;
  logic [dataW-1:0] div_quo, div_rem;
  logic [2*dataW-1:0] a_ext, b_ext, prod;
  logic [dataW-1:0] mul_result, special_result, div_result;

  assign op_in      = muldiv_op_e'(req_op);
  assign accept     = (state == IDLE) && req_valid && !flush;
  assign sgn_in     = is_div(op_in) && is_signed_a(op_in);
  assign special_in = is_div(op_in) &&
                      ((req_b == '0) || (sgn_in && (req_a == MIN_VAL) && (req_b == '1)));
  assign a_abs      = (sgn_in && req_a[dataW-1]) ? -req_a : req_a;
  assign b_abs      = (sgn_in && req_b[dataW-1]) ? -req_b : req_b;
  assign div_start  = accept && is_div(op_in) && !special_in;

  muldiv_div_iter #(.dataW(dataW)) u_div (
    .clk      (clk),
    .nReset   (nReset),
    .start    (div_start),
    .clear    (flush),
    .dividend (a_abs),
    .divisor  (b_abs),
    .quo      (div_quo),
    .rem      (div_rem),
    .done     (div_done)
  );

  // Result selection for multiply, divide special cases and sign-fixed divide
  always_comb begin
    a_ext          = {{dataW{is_signed_a(op_q) & a_q[dataW-1]}}, a_q};
    b_ext          = {{dataW{is_signed_b(op_q) & b_q[dataW-1]}}, b_q};
    prod           = a_ext * b_ext;
    mul_result     = (op_q == OP_MUL) ? prod[dataW-1:0] : prod[2*dataW-1:dataW];
    special_result = (b_q == '0) ? (is_rem(op_q) ? a_q : '1)
                                 : (is_rem(op_q) ? '0  : MIN_VAL);
    if (is_rem(op_q)) div_result = neg_r ? -div_rem : div_rem;
    else              div_result = neg_q ? -div_quo : div_quo;
  end

  // State register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = is_div(op_in) ? DIV : MUL;
      MUL:  state_next = DONE;
      DIV:  if (special_q || div_done) state_next = DONE;
      DONE: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Operand capture at acceptance and result registration on entry to DONE
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      op_q      <= OP_MUL;
      a_q       <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      special_q <= 1'b0;
      resp_data <= '0;
    end else begin
      if (accept) begin
        op_q      <= op_in;
        a_q       <= req_a;
        b_q       <= req_b;
        neg_q     <= sgn_in && (req_a[dataW-1] ^ req_b[dataW-1]);
        neg_r     <= sgn_in && req_a[dataW-1];
        special_q <= special_in;
      end
      if (!flush) begin
        if (state == MUL)                  resp_data <= mul_result;
        else if (state == DIV && special_q) resp_data <= special_result;
        else if (state == DIV && div_done)  resp_data <= div_result;
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed bench for muldiv_seq_ctrl: latency, results, backpressure, flush, reset.
module tb_muldiv_seq_ctrl;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                         OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                         OP_REM = 3'b110, OP_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        busy;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  muldiv_seq_ctrl #(.dataW(32)) dut (
    .clk        (clk),
    .nReset     (nReset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request, count edges until resp_valid, compare against scoreboard.
  // resp_ready is high, so the handshake completes on the following edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    logic [31:0] e;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; resp_ready = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (resp_valid) break;
      lat++;
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    e = exp_q.pop_front();
    check_eq({tag, "_data"}, resp_data, e);
  endtask

  initial begin
    int bad;
    int lat;
    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_resp_data", resp_data, 32'd0);
    check_eq("rst_state", {30'b0, state_dbg}, 32'd0);
    nReset = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // multiplies: one edge to result
    run_op("mul",    OP_MUL,    32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1);
    run_op("mulh",   OP_MULH,   32'h80000000,  32'h80000000, 32'h40000000, 1);
    run_op("mulhu",  OP_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 1);
    run_op("mulhsu", OP_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    run_op("mulh_pos", OP_MULH, 32'h00010000,  32'h00030000, 32'h00000003, 1);

    // iterative divides: 33 edges
    run_op("div_neg",  OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem_neg",  OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",     OP_DIVU, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu",     OP_REMU, 32'd100,      32'd7,        32'd2,        33);
    run_op("div_negb", OP_DIV,  32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33);
    run_op("rem_negb", OP_REM,  32'd20,       32'hFFFFFFFD, 32'd2,        33);
    run_op("divu_max", OP_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33);
    run_op("remu_big", OP_REMU, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        33);

    // special cases: one edge
    run_op("divu_z",  OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_z",   OP_REM,  32'd5,        32'd0,        32'd5,        1);
    run_op("div_ovf", OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf", OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // backpressure: result held 10 cycles, new requests ignored
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_MUL; req_a = 32'd3; req_b = 32'd5; resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 100 && !resp_valid) begin
      @(negedge clk);
      lat++;
    end
    check_eq("hold_lat", lat, 2);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!resp_valid || resp_data !== 32'd15 || req_ready) bad++;
      req_valid = 1'b1; req_op = OP_MULHU; req_a = 32'd9; req_b = 32'd9;
      @(negedge clk);
    end
    check_eq("hold_stable", bad, 0);
    check_eq("hold_data", resp_data, 32'd15);
    resp_ready = 1'b1;  // handshake with req_valid still high
    @(negedge clk);
    check_eq("hs_no_same_cycle", {31'b0, busy}, 32'd0);
    check_eq("hs_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("hs_req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b0;

    // flush mid-divide
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd100; req_b = 32'd7;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check_eq("div_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_state", {30'b0, state_dbg}, 32'd0);
    check_eq("flush_resp_valid", {31'b0, resp_valid}, 32'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid || busy) bad++;
    end
    check_eq("flush_quiet", bad, 0);
    run_op("post_flush_rem_z", OP_REM, 32'd5, 32'd0, 32'd5, 1);

    // flush in IDLE beats req_valid
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_MUL; req_a = 32'd2; req_b = 32'd2; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check_eq("flush_idle_busy", {31'b0, busy}, 32'd0);

    // flush in DONE beats resp_ready
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_MUL; req_a = 32'd6; req_b = 32'd7; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("done_data", resp_data, 32'd42);
    flush = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_done_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("flush_done_busy", {31'b0, busy}, 32'd0);

    // async reset in the middle of a multiply
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_MUL; req_a = 32'd11; req_b = 32'd13;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check_eq("mid_mul_state", {30'b0, state_dbg}, 32'd1);
    nReset = 1'b0;
    #1;
    check_eq("arst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("arst_busy", {31'b0, busy}, 32'd0);
    check_eq("arst_resp_data", resp_data, 32'd0);
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
    check_eq("arst_req_ready", {31'b0, req_ready}, 32'd1);
    run_op("post_rst_mul", OP_MUL, 32'd11, 32'd13, 32'd143, 1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
